// File: rtl/arp_ctrl_if.sv
// ARP transmit request bus between the resolution controller (master) and the ARP framer (slave).
interface arp_ctrl_if;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [15:0] o_tx_op;
    logic [47:0] o_tx_dst_mac;
    logic [31:0] o_tx_dst_ip;

    modport master (
        output o_tx_valid, o_tx_op, o_tx_dst_mac, o_tx_dst_ip,
        input  i_tx_ready
    );

    modport slave (
        input  o_tx_valid, o_tx_op, o_tx_dst_mac, o_tx_dst_ip,
        output i_tx_ready
    );
endinterface

// File: rtl/arp_ctrl.sv
// ARP resolution controller: single-entry IP->MAC cache, request/retry FSM, reply scheduling.
// Optional cache aging is enabled by defining ARP_CACHE_AGE_EN.
module arp_ctrl #(
    parameter int          P_TIMEOUT_CYC = 1_250_000,
    parameter int          P_MAX_RETRY   = 3,
    parameter logic [31:0] P_AGE_CYC     = 32'd3_750_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] i_rx_dst_mac,
    input  logic [31:0] i_rx_dst_ip,
    input  logic        i_rx_dst_valid,
    input  logic        i_rx_trig_reply,
    input  logic [31:0] i_lookup_ip,
    input  logic        i_lookup_valid,
    output logic        o_lookup_ready,
    output logic [47:0] o_lookup_mac,
    output logic        o_lookup_done,
    output logic        o_lookup_fail,
    arp_ctrl_if.master  tx
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CHECK    = 2'd1;
    localparam logic [1:0] ST_SEND_REQ = 2'd2;
    localparam logic [1:0] ST_WAIT     = 2'd3;

    localparam int TW = $clog2(P_TIMEOUT_CYC + 1);
    localparam int RW = $clog2(P_MAX_RETRY + 1);

    logic [1:0]    state, state_nxt;
    logic          run;
    logic [31:0]   target_ip;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic [31:0]   cache_ip;
    logic [47:0]   cache_mac;
    logic          cache_vld;
    logic          age_expire;
    logic          rply_pend, rply_dirty;
    logic [47:0]   rply_mac;
    logic [31:0]   rply_ip;

    logic tx_hs, req_hs, rply_hs, hit, rx_match, timeout, retry_left;

    // run keeps ready low while reset is held, then tracks IDLE
    assign o_lookup_ready = run & (state == ST_IDLE);
    assign tx_hs      = tx.o_tx_valid & tx.i_tx_ready;
    assign req_hs     = tx_hs & (tx.o_tx_op == 16'd1);
    assign rply_hs    = tx_hs & (tx.o_tx_op == 16'd2);
    assign hit        = cache_vld & (cache_ip == target_ip);
    assign rx_match   = i_rx_dst_valid & (i_rx_dst_ip == target_ip);
    assign timeout    = (timer == TW'(P_TIMEOUT_CYC - 1));
    assign retry_left = (retry < RW'(P_MAX_RETRY));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (i_lookup_valid && o_lookup_ready) state_nxt = ST_CHECK;
            ST_CHECK:    state_nxt = hit ? ST_IDLE : ST_SEND_REQ;
            ST_SEND_REQ: if (req_hs) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (rx_match)     state_nxt = ST_IDLE;
                else if (timeout) state_nxt = retry_left ? ST_SEND_REQ : ST_IDLE;
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            run           <= 1'b0;
            target_ip     <= '0;
            timer         <= '0;
            retry         <= '0;
            o_lookup_mac  <= '0;
            o_lookup_done <= 1'b0;
            o_lookup_fail <= 1'b0;
        end else begin
            state         <= state_nxt;
            run           <= 1'b1;
            o_lookup_done <= 1'b0;
            o_lookup_fail <= 1'b0;
            if (state == ST_IDLE && state_nxt == ST_CHECK) begin
                target_ip <= i_lookup_ip;
                retry     <= '0;
            end
            if (state == ST_CHECK && hit) begin
                o_lookup_done <= 1'b1;
                o_lookup_mac  <= cache_mac;
            end
            if (state == ST_SEND_REQ && req_hs) begin
                timer <= '0;
                if (retry != RW'(P_MAX_RETRY)) retry <= retry + 1'b1;
            end
            if (state == ST_WAIT) begin
                if (!timeout) timer <= timer + 1'b1;
                if (rx_match) begin
                    o_lookup_done <= 1'b1;
                    o_lookup_mac  <= i_rx_dst_mac;
                end else if (timeout && !retry_left) begin
                    o_lookup_fail <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cache_vld <= 1'b0;
            cache_ip  <= '0;
            cache_mac <= '0;
        end else if (i_rx_dst_valid) begin
            cache_vld <= 1'b1;
            cache_ip  <= i_rx_dst_ip;
            cache_mac <= i_rx_dst_mac;
        end else if (age_expire) begin
            cache_vld <= 1'b0;
        end
    end

`ifdef ARP_CACHE_AGE_EN
    logic [31:0] age;
    assign age_expire = cache_vld & (age == P_AGE_CYC - 32'd1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                             age <= '0;
        else if (i_rx_dst_valid)               age <= '0;
        else if (cache_vld && !age_expire)     age <= age + 32'd1;
    end
`else
    logic unused_age;
    assign age_expire = 1'b0;
    assign unused_age = ^P_AGE_CYC;
`endif

    // dirty marks a trigger that arrived while the port was busy, so the in-flight
    // reply's handshake must not retire it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rply_pend  <= 1'b0;
            rply_dirty <= 1'b0;
            rply_mac   <= '0;
            rply_ip    <= '0;
        end else if (i_rx_trig_reply) begin
            rply_pend  <= 1'b1;
            rply_dirty <= tx.o_tx_valid;
            rply_mac   <= i_rx_dst_mac;
            rply_ip    <= i_rx_dst_ip;
        end else if (rply_hs) begin
            rply_pend  <= rply_dirty;
        end else if (!tx.o_tx_valid && rply_pend) begin
            rply_dirty <= 1'b0;
        end
    end

    // replies take priority whenever the port is idle; fields freeze while valid
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx.o_tx_valid   <= 1'b0;
            tx.o_tx_op      <= '0;
            tx.o_tx_dst_mac <= '0;
            tx.o_tx_dst_ip  <= '0;
        end else if (tx_hs) begin
            tx.o_tx_valid   <= 1'b0;
        end else if (!tx.o_tx_valid) begin
            if (i_rx_trig_reply) begin
                tx.o_tx_valid   <= 1'b1;
                tx.o_tx_op      <= 16'd2;
                tx.o_tx_dst_mac <= i_rx_dst_mac;
                tx.o_tx_dst_ip  <= i_rx_dst_ip;
            end else if (rply_pend) begin
                tx.o_tx_valid   <= 1'b1;
                tx.o_tx_op      <= 16'd2;
                tx.o_tx_dst_mac <= rply_mac;
                tx.o_tx_dst_ip  <= rply_ip;
            end else if (state_nxt == ST_SEND_REQ) begin
                tx.o_tx_valid   <= 1'b1;
                tx.o_tx_op      <= 16'd1;
                tx.o_tx_dst_mac <= 48'hFFFF_FFFF_FFFF;
                tx.o_tx_dst_ip  <= target_ip;
            end
        end
    end
endmodule

// File: tb/tb_arp_ctrl.sv
// Directed bench for arp_ctrl: hit, resolved miss, timeout/retry, reply arbitration, reset, aging.
module tb_arp_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] rx_dst_mac;
    logic [31:0] rx_dst_ip;
    logic        rx_dst_valid;
    logic        rx_trig_reply;
    logic [31:0] lookup_ip;
    logic        lookup_valid;
    logic        lookup_ready;
    logic [47:0] lookup_mac;
    logic        lookup_done;
    logic        lookup_fail;

    int checks = 0;
    int errors = 0;

    arp_ctrl_if txb ();

    arp_ctrl #(
        .P_TIMEOUT_CYC (50),
        .P_MAX_RETRY   (3),
        .P_AGE_CYC     (32'd200)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_rx_dst_mac    (rx_dst_mac),
        .i_rx_dst_ip     (rx_dst_ip),
        .i_rx_dst_valid  (rx_dst_valid),
        .i_rx_trig_reply (rx_trig_reply),
        .i_lookup_ip     (lookup_ip),
        .i_lookup_valid  (lookup_valid),
        .o_lookup_ready  (lookup_ready),
        .o_lookup_mac    (lookup_mac),
        .o_lookup_done   (lookup_done),
        .o_lookup_fail   (lookup_fail),
        .tx              (txb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 64'(lookup_ready), 64'd0);
        chk({tag, "_txv"},   64'(txb.o_tx_valid), 64'd0);
        chk({tag, "_done"},  64'(lookup_done), 64'd0);
        chk({tag, "_fail"},  64'(lookup_fail), 64'd0);
        chk({tag, "_mac"},   64'(lookup_mac), 64'd0);
        chk({tag, "_op"},    64'(txb.o_tx_op), 64'd0);
        chk({tag, "_txmac"}, 64'(txb.o_tx_dst_mac), 64'd0);
        chk({tag, "_txip"},  64'(txb.o_tx_dst_ip), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nreq, nfail, ndone, nbad;
        int t1, t2, t3;

        rst = 1'b1;
        rx_dst_mac = '0; rx_dst_ip = '0; rx_dst_valid = 1'b0; rx_trig_reply = 1'b0;
        lookup_ip = '0; lookup_valid = 1'b0; txb.i_tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();
        chk("ready_after_reset", 64'(lookup_ready), 64'd1);

        // cache hit
        rx_dst_ip = 32'hC0A8_0A00; rx_dst_mac = 48'h0011_2233_4455; rx_dst_valid = 1'b1;
        tick();
        rx_dst_valid = 1'b0;
        lookup_ip = 32'hC0A8_0A00; lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        chk("hit_check_ready", 64'(lookup_ready), 64'd0);
        chk("hit_check_done", 64'(lookup_done), 64'd0);
        tick();
        chk("hit_done", 64'(lookup_done), 64'd1);
        chk("hit_mac", 64'(lookup_mac), 64'h0011_2233_4455);
        chk("hit_no_tx", 64'(txb.o_tx_valid), 64'd0);
        tick();
        chk("hit_done_pulse", 64'(lookup_done), 64'd0);
        chk("hit_ready_again", 64'(lookup_ready), 64'd1);

        // miss resolved by a reply
        txb.i_tx_ready = 1'b1;
        lookup_ip = 32'hC0A8_0A05; lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        chk("miss_check_txv", 64'(txb.o_tx_valid), 64'd0);
        tick();
        chk("miss_req_valid", 64'(txb.o_tx_valid), 64'd1);
        chk("miss_req_op", 64'(txb.o_tx_op), 64'd1);
        chk("miss_req_mac", 64'(txb.o_tx_dst_mac), 64'hFFFF_FFFF_FFFF);
        chk("miss_req_ip", 64'(txb.o_tx_dst_ip), 64'hC0A8_0A05);
        tick();
        chk("miss_req_drop", 64'(txb.o_tx_valid), 64'd0);
        nbad = 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (txb.o_tx_valid || lookup_done || lookup_fail) nbad++;
        end
        chk("miss_wait_quiet", 64'(nbad), 64'd0);
        rx_dst_ip = 32'hC0A8_0A05; rx_dst_mac = 48'hAABB_CCDD_EEFF; rx_dst_valid = 1'b1;
        tick();
        rx_dst_valid = 1'b0;
        chk("resolve_done", 64'(lookup_done), 64'd1);
        chk("resolve_mac", 64'(lookup_mac), 64'hAABB_CCDD_EEFF);
        tick();
        chk("resolve_ready", 64'(lookup_ready), 64'd1);
        lookup_ip = 32'hC0A8_0A05; lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        tick();
        chk("learned_hit_done", 64'(lookup_done), 64'd1);
        chk("learned_hit_no_tx", 64'(txb.o_tx_valid), 64'd0);
        tick();

        // timeout with retries
        lookup_ip = 32'hC0A8_0A07; lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        nreq = 0; nfail = 0; ndone = 0; t1 = 0; t2 = 0; t3 = 0;
        for (int i = 0; i < 200; i++) begin
            if (txb.o_tx_valid && txb.i_tx_ready) begin
                nreq++;
                if (nreq == 1) t1 = i;
                if (nreq == 2) t2 = i;
                if (nreq == 3) t3 = i;
            end
            if (lookup_fail) nfail++;
            if (lookup_done) ndone++;
            tick();
        end
        chk("to_requests", 64'(nreq), 64'd3);
        chk("to_gap1", 64'((t2 - t1) >= 50), 64'd1);
        chk("to_gap2", 64'((t3 - t2) >= 50), 64'd1);
        chk("to_fail_count", 64'(nfail), 64'd1);
        chk("to_no_done", 64'(ndone), 64'd0);
        chk("to_ready", 64'(lookup_ready), 64'd1);

        // reply wins the port against a simultaneous request, stalled 5 cycles
        txb.i_tx_ready = 1'b0;
        lookup_ip = 32'hC0A8_0A0B; lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        rx_dst_ip = 32'hC0A8_0A09; rx_dst_mac = 48'h0200_0000_0009; rx_trig_reply = 1'b1;
        tick();
        rx_trig_reply = 1'b0;
        rx_dst_ip = 32'h0; rx_dst_mac = 48'h0;
        chk("arb_reply_valid", 64'(txb.o_tx_valid), 64'd1);
        chk("arb_reply_op", 64'(txb.o_tx_op), 64'd2);
        chk("arb_reply_mac", 64'(txb.o_tx_dst_mac), 64'h0200_0000_0009);
        chk("arb_reply_ip", 64'(txb.o_tx_dst_ip), 64'hC0A8_0A09);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("arb_stall_op", 64'(txb.o_tx_op), 64'd2);
            chk("arb_stall_mac", 64'(txb.o_tx_dst_mac), 64'h0200_0000_0009);
        end
        txb.i_tx_ready = 1'b1;
        tick();
        txb.i_tx_ready = 1'b0;
        chk("arb_reply_drop", 64'(txb.o_tx_valid), 64'd0);
        tick();
        chk("arb_req_valid", 64'(txb.o_tx_valid), 64'd1);
        chk("arb_req_op", 64'(txb.o_tx_op), 64'd1);
        chk("arb_req_mac", 64'(txb.o_tx_dst_mac), 64'hFFFF_FFFF_FFFF);
        chk("arb_req_ip", 64'(txb.o_tx_dst_ip), 64'hC0A8_0A0B);
        txb.i_tx_ready = 1'b1;
        tick();
        txb.i_tx_ready = 1'b0;
        nbad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (txb.o_tx_valid) nbad++;
        end
        chk("arb_no_resend", 64'(nbad), 64'd0);

        // asynchronous reset during WAIT
        rst = 1'b1;
        #1;
        chk_idle_outputs("midrst");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_ready", 64'(lookup_ready), 64'd1);
        nbad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (lookup_done || lookup_fail || txb.o_tx_valid) nbad++;
        end
        chk("midrst_quiet", 64'(nbad), 64'd0);
        txb.i_tx_ready = 1'b1;
        lookup_ip = 32'hC0A8_0A05; lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        tick();
        chk("midrst_cache_miss_done", 64'(lookup_done), 64'd0);
        chk("midrst_cache_miss_req", 64'(txb.o_tx_valid), 64'd1);
        chk("midrst_cache_miss_ip", 64'(txb.o_tx_dst_ip), 64'hC0A8_0A05);
        tick();

`ifdef ARP_CACHE_AGE_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rx_dst_ip = 32'hC0A8_0A00; rx_dst_mac = 48'h0011_2233_4455; rx_dst_valid = 1'b1;
        tick();
        rx_dst_valid = 1'b0;
        repeat (149) tick();
        lookup_ip = 32'hC0A8_0A00; lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        tick();
        chk("age_early_hit", 64'(lookup_done), 64'd1);
        repeat (98) tick();
        lookup_ip = 32'hC0A8_0A00; lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        tick();
        chk("age_late_done", 64'(lookup_done), 64'd0);
        chk("age_late_req", 64'(txb.o_tx_valid), 64'd1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
